// File: rtl/reel_spin_scheduler.sv
// Speed-profile sequencer for one slot-machine reel: accelerates, spins, decelerates
// and lands the reel on a symbol boundary by driving the reel clock divider's speed input.
module reel_spin_scheduler #(
  parameter int unsigned MAX_SPEED    = 50000000,
  parameter int unsigned TOP_SPEED    = 40,
  parameter int unsigned MIN_SPEED    = 2,
  parameter int unsigned STEP         = 2,
  parameter int unsigned TICK_CYCLES  = 5000000,
  parameter int unsigned SPIN_TICKS   = 20,
  parameter int unsigned LAND_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop_req,
  input  logic        reel_tick,
  output logic [25:0] speed,
  output logic        run,
  output logic        busy,
  output logic        done,
  output logic        land_fault
);

  localparam int unsigned SPEED_W = 26;
  localparam int unsigned PRESC_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CNT_MAX = (SPIN_TICKS > LAND_TIMEOUT) ? SPIN_TICKS : LAND_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [SPEED_W-1:0] TOP_S      = SPEED_W'(TOP_SPEED);
  localparam logic [SPEED_W-1:0] MIN_S      = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W:0]   STEP_W     = (SPEED_W + 1)'(STEP);
  localparam logic [SPEED_W:0]   DECEL_FLOOR = (SPEED_W + 1)'(MIN_SPEED) + STEP_W;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0]   LAND_LAST  = CNT_W'(LAND_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_SPIN,
    S_DECEL,
    S_LAND,
    S_FINISH
  } state_e;

  // Parameter sanity: the divider divides by speed, so a zero or out-of-range value is fatal.
  if (MIN_SPEED < 1) begin : g_bad_min
    $error("reel_spin_scheduler: MIN_SPEED must be >= 1");
  end
  if (MIN_SPEED > TOP_SPEED) begin : g_bad_range
    $error("reel_spin_scheduler: MIN_SPEED must not exceed TOP_SPEED");
  end
  if (TOP_SPEED > MAX_SPEED) begin : g_bad_top
    $error("reel_spin_scheduler: TOP_SPEED must not exceed MAX_SPEED");
  end
  if (STEP < 1) begin : g_bad_step
    $error("reel_spin_scheduler: STEP must be >= 1");
  end
  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("reel_spin_scheduler: TICK_CYCLES must be >= 2");
  end
  if (SPIN_TICKS < 1) begin : g_bad_spin
    $error("reel_spin_scheduler: SPIN_TICKS must be >= 1");
  end
  if (LAND_TIMEOUT < 1) begin : g_bad_land
    $error("reel_spin_scheduler: LAND_TIMEOUT must be >= 1");
  end

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [2:0]           reel_sync_q;

  logic                 tick;
  logic                 rise;
  logic                 start_accept;
  logic [SPEED_W:0]     accel_sum;
  logic [SPEED_W-1:0]   accel_speed;
  logic [SPEED_W:0]     decel_diff;
  logic [SPEED_W-1:0]   decel_speed;

  // reel_tick is asynchronous: two flops to synchronise, a third to find the rising edge.
  assign rise = reel_sync_q[1] & ~reel_sync_q[2];

  assign start_accept = (state_q == S_IDLE) && start;
  assign tick         = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (start_accept || tick) begin
      presc_d = '0;
    end
  end

  // Arithmetic is one bit wider than speed so saturation never sees a wrapped value.
  assign accel_sum   = {1'b0, speed_q} + STEP_W;
  assign accel_speed = (accel_sum >= {1'b0, TOP_S}) ? TOP_S : accel_sum[SPEED_W-1:0];
  assign decel_diff  = {1'b0, speed_q} - STEP_W;
  assign decel_speed = ({1'b0, speed_q} >= DECEL_FLOOR) ? decel_diff[SPEED_W-1:0] : MIN_S;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      speed_q     <= MIN_S;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      presc_q     <= '0;
      reel_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      presc_q     <= presc_d;
      reel_sync_q <= {reel_sync_q[1:0], reel_tick};
    end
  end

  // NOTE: every next-state value is defaulted to hold first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEL;
          speed_d = MIN_S;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end

      S_ACCEL: begin
        if (stop_req) begin
          state_d = S_DECEL;
        end else if (tick) begin
          speed_d = accel_speed;
          if (accel_speed == TOP_S) begin
            state_d = S_SPIN;
            cnt_d   = '0;
          end
        end
      end

      S_SPIN: begin
        if (stop_req) begin
          state_d = S_DECEL;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == SPIN_LAST) begin
            state_d = S_DECEL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DECEL: begin
        if (tick) begin
          speed_d = decel_speed;
          if (decel_speed == MIN_S) begin
            state_d = S_LAND;
            cnt_d   = '0;
          end
        end
      end

      S_LAND: begin
        speed_d = MIN_S;
        // A symbol-boundary rise wins over a coincident timeout.
        if (rise) begin
          state_d = S_FINISH;
        end else if (tick) begin
          if (cnt_q == LAND_LAST) begin
            state_d = S_FINISH;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        speed_d = MIN_S;
      end
    endcase
  end

  always_comb begin
    speed      = speed_q;
    land_fault = fault_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FINISH);
    run        = (state_q == S_ACCEL) || (state_q == S_SPIN) ||
                 (state_q == S_DECEL) || (state_q == S_LAND);
  end

endmodule

// File: tb/tb_reel_spin_scheduler.sv
// Directed bench for reel_spin_scheduler: a checkpoint table for the timed profile,
// plus hand-written sequences for landing latency, saturation and reset abort.
module tb_reel_spin_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop_req = 1'b0;
  logic        reel_tick = 1'b0;
  logic [25:0] speed;
  logic        run, busy, done, land_fault;

  logic        start_s = 1'b0;
  logic        stop_s = 1'b0;
  logic [25:0] speed_s;
  logic        run_s, busy_s, done_s, fault_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reel_spin_scheduler #(
    .MAX_SPEED(50000000), .TOP_SPEED(10), .MIN_SPEED(2), .STEP(4),
    .TICK_CYCLES(4), .SPIN_TICKS(3), .LAND_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .reel_tick(reel_tick),
    .speed(speed), .run(run), .busy(busy), .done(done), .land_fault(land_fault)
  );

  reel_spin_scheduler #(
    .MAX_SPEED(50000000), .TOP_SPEED(10), .MIN_SPEED(2), .STEP(3),
    .TICK_CYCLES(4), .SPIN_TICKS(3), .LAND_TIMEOUT(4)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stop_req(stop_s), .reel_tick(reel_tick),
    .speed(speed_s), .run(run_s), .busy(busy_s), .done(done_s), .land_fault(fault_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // One checkpoint: pulse start/stop for one edge, advance n edges, then compare outputs.
  typedef struct {
    int unsigned n;
    logic        start;
    logic        stop;
    int unsigned speed;
    logic        run;
    logic        busy;
    logic        done;
    logic        fault;
  } vec_t;

  vec_t vecs[26];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_rise, c, done_cnt, lat, hold, viol, bad, fin_fault;
    logic finished;
    int seq[$];
    int exp_main[5] = '{2, 6, 10, 6, 2};
    int exp_sat[7]  = '{2, 5, 8, 10, 7, 4, 2};

    //             n  st sp spd run busy done fault
    vecs[0]  = '{ 1, 1, 0,  2, 1, 1, 0, 0};  // start accepted, busy next cycle
    vecs[1]  = '{ 3, 0, 0,  2, 1, 1, 0, 0};  // no tick yet
    vecs[2]  = '{ 1, 0, 0,  6, 1, 1, 0, 0};  // tick 1
    vecs[3]  = '{ 4, 0, 0, 10, 1, 1, 0, 0};  // tick 2 -> SPIN
    vecs[4]  = '{ 1, 1, 0, 10, 1, 1, 0, 0};  // start while busy ignored
    vecs[5]  = '{11, 0, 0, 10, 1, 1, 0, 0};  // 3 spin ticks -> DECEL
    vecs[6]  = '{ 4, 0, 0,  6, 1, 1, 0, 0};
    vecs[7]  = '{ 4, 0, 0,  2, 1, 1, 0, 0};  // LAND
    vecs[8]  = '{15, 0, 0,  2, 1, 1, 0, 0};  // one clk before timeout
    vecs[9]  = '{ 1, 0, 0,  2, 0, 1, 1, 1};  // timeout finish
    vecs[10] = '{ 1, 0, 0,  2, 0, 0, 0, 1};  // IDLE, fault sticky
    vecs[11] = '{ 1, 1, 0,  2, 1, 1, 0, 0};  // new start clears fault
    vecs[12] = '{ 4, 0, 0,  6, 1, 1, 0, 0};
    vecs[13] = '{ 1, 0, 1,  6, 1, 1, 0, 0};  // early stop in ACCEL
    vecs[14] = '{ 3, 0, 0,  2, 1, 1, 0, 0};  // decel 6->2, never 10
    vecs[15] = '{16, 0, 0,  2, 0, 1, 1, 1};
    vecs[16] = '{ 1, 0, 0,  2, 0, 0, 0, 1};
    vecs[17] = '{ 1, 1, 1,  2, 1, 1, 0, 0};  // start+stop in IDLE
    vecs[18] = '{ 4, 0, 0,  6, 1, 1, 0, 0};  // stop was ignored
    vecs[19] = '{ 4, 0, 0, 10, 1, 1, 0, 0};
    vecs[20] = '{ 3, 0, 0, 10, 1, 1, 0, 0};
    vecs[21] = '{ 1, 0, 1, 10, 1, 1, 0, 0};  // stop coincident with spin tick
    vecs[22] = '{ 4, 0, 0,  6, 1, 1, 0, 0};  // decel already under way
    vecs[23] = '{ 4, 0, 0,  2, 1, 1, 0, 0};
    vecs[24] = '{16, 0, 0,  2, 0, 1, 1, 1};
    vecs[25] = '{ 1, 0, 0,  2, 0, 0, 0, 1};

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b0;
    #1;
    check("rst.speed", 32'(speed), 2);
    check("rst.run", 32'(run), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.fault", 32'(land_fault), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();

    for (int i = 0; i < 26; i++) begin
      start    = vecs[i].start;
      stop_req = vecs[i].stop;
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        step();
        start    = 1'b0;
        stop_req = 1'b0;
      end
      check($sformatf("vec%0d.speed", i), 32'(speed), vecs[i].speed);
      check($sformatf("vec%0d.run", i), 32'(run), 32'(vecs[i].run));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d.fault", i), 32'(land_fault), 32'(vecs[i].fault));
    end

    // Reset in the middle of SPIN aborts without a done pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("abort.pre_speed", 32'(speed), 10);
    #2 rst = 1'b0;
    #1;
    check("abort.speed", 32'(speed), 2);
    check("abort.busy", 32'(busy), 0);
    check("abort.run", 32'(run), 0);
    check("abort.done", 32'(done), 0);
    bad = 0;
    repeat (3) begin
      step();
      if (done || busy) bad++;
    end
    @(negedge clk) rst = 1'b1;
    repeat (6) begin
      step();
      if (done || busy || speed != 2) bad++;
    end
    check("abort.quiet", 32'(bad), 0);

    // Full profile with reel_tick toggling every 6 clks.
    reel_tick = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    seq = {};
    seq.push_back(int'(speed));
    last_rise = -100; done_cnt = 0; lat = -1; hold = 0; viol = 0; fin_fault = -1;
    finished = 1'b0;
    c = 0;
    while (c < 200 && !finished) begin
      if (c > 0) step();
      if (int'(speed) != seq[$]) seq.push_back(int'(speed));
      if (speed < 2 || speed > 10) viol++;
      if (speed == 10) hold++;
      if (done) begin
        done_cnt++;
        lat = c - last_rise;
        fin_fault = int'(land_fault);
      end
      if (done_cnt > 0 && !busy) finished = 1'b1;
      if (c % 6 == 5) begin
        reel_tick = ~reel_tick;
        if (reel_tick) last_rise = c;
      end
      c++;
    end
    check("prof.finished", 32'(finished), 1);
    check("prof.seq_len", 32'(seq.size()), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++)
      check($sformatf("prof.seq%0d", i), 32'(seq[i]), 32'(exp_main[i]));
    check("prof.hold_cycles", 32'(hold), 16);
    check("prof.done_pulses", 32'(done_cnt), 1);
    check("prof.rise_to_done", 32'(lat), 3);
    check("prof.fault", 32'(fin_fault), 0);
    check("prof.range", 32'(viol), 0);

    // Saturating arithmetic with STEP=3.
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    seq = {};
    seq.push_back(int'(speed_s));
    viol = 0; done_cnt = 0; finished = 1'b0;
    c = 0;
    while (c < 200 && !finished) begin
      if (c > 0) step();
      if (int'(speed_s) != seq[$]) seq.push_back(int'(speed_s));
      if (speed_s < 2 || speed_s > 10) viol++;
      if (done_s) done_cnt++;
      if (done_cnt > 0 && !busy_s) finished = 1'b1;
      if (c % 6 == 5) reel_tick = ~reel_tick;
      c++;
    end
    check("sat.finished", 32'(finished), 1);
    check("sat.seq_len", 32'(seq.size()), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++)
      check($sformatf("sat.seq%0d", i), 32'(seq[i]), 32'(exp_sat[i]));
    check("sat.range", 32'(viol), 0);
    check("sat.done_pulses", 32'(done_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
